// File: rtl/rpc_cmd_arbiter.sv
// Merges refresh, ZQ-calibration and direct register commands into one registered
// command channel towards the CMD_FSM, with fixed priority plus starvation promotion.
module rpc_cmd_arbiter #(
    parameter int CMD_WIDTH        = 19,
    parameter int STARVE_LIMIT     = 16,
    parameter int STARVE_CNT_WIDTH = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rpc_init_completed_i,
    input  logic                 ref_valid_i,
    output logic                 ref_ready_o,
    input  logic [CMD_WIDTH-1:0] ref_cmd_i,
    input  logic                 zqc_valid_i,
    output logic                 zqc_ready_o,
    input  logic [CMD_WIDTH-1:0] zqc_cmd_i,
    input  logic                 direct_cmd_valid_i,
    output logic                 direct_cmd_ready_o,
    input  logic [CMD_WIDTH-1:0] direct_cmd_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [CMD_WIDTH-1:0] cmd_o,
    output logic [1:0]           cmd_src_o,
    output logic                 busy_o
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_WIDTH-1:0] ONE   = STARVE_CNT_WIDTH'(1);

    state_t                      state_q, state_d;
    logic [2:0]                  eligible, urgent, pool, grant;
    logic [STARVE_CNT_WIDTH-1:0] wait_cnt_q [3];
    logic [CMD_WIDTH-1:0]        cmd_d;
    logic [1:0]                  src_d;

    // Bit order everywhere: 0 = ref, 1 = zqc, 2 = direct.
    always_comb begin
        eligible = {direct_cmd_valid_i, zqc_valid_i, ref_valid_i} & {3{rpc_init_completed_i}};
        for (int i = 0; i < 3; i++) begin
            urgent[i] = (wait_cnt_q[i] == LIMIT);
        end
        pool = (|(eligible & urgent)) ? (eligible & urgent) : eligible;
    end

    always_comb begin
        state_d = state_q;
        grant   = 3'b000;
        unique case (state_q)
            IDLE: begin
                if (rst_ni) begin
                    if (pool[0])      grant = 3'b001;
                    else if (pool[1]) grant = 3'b010;
                    else if (pool[2]) grant = 3'b100;
                end
                if (|grant) state_d = HOLD;
            end
            HOLD: begin
                if (cmd_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_d = ref_cmd_i;
        src_d = 2'd0;
        if (grant[1]) begin
            cmd_d = zqc_cmd_i;
            src_d = 2'd1;
        end else if (grant[2]) begin
            cmd_d = direct_cmd_i;
            src_d = 2'd2;
        end
    end

    assign ref_ready_o        = grant[0];
    assign zqc_ready_o        = grant[1];
    assign direct_cmd_ready_o = grant[2];
    assign cmd_valid_o        = (state_q == HOLD);
    assign busy_o             = (state_q == HOLD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cmd_o     <= '0;
            cmd_src_o <= 2'd0;
        end else begin
            state_q <= state_d;
            if (|grant) begin
                cmd_o     <= cmd_d;
                cmd_src_o <= src_d;
            end
        end
    end

    // Counters keep running in HOLD so a source waiting behind a stalled command still ages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 3; i++) wait_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (grant[i])
                    wait_cnt_q[i] <= '0;
                else if (eligible[i])
                    wait_cnt_q[i] <= urgent[i] ? wait_cnt_q[i] : wait_cnt_q[i] + ONE;
                else
                    wait_cnt_q[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Directed bench for rpc_cmd_arbiter (STARVE_LIMIT=4): inputs change on the falling edge,
// outputs are compared 1 time unit later, well away from the rising edge.
module tb_rpc_cmd_arbiter;

    localparam logic [18:0] REF_CMD = 19'h12345;
    localparam logic [18:0] ZQC_CMD = 19'h2ABCD;
    localparam logic [18:0] DIR_CMD = 19'h5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic        ref_valid, zqc_valid, dir_valid, cmd_ready;
    logic [18:0] ref_cmd, zqc_cmd, dir_cmd;
    logic        ref_ready, zqc_ready, dir_ready;
    logic        cmd_valid, busy;
    logic [18:0] cmd_out;
    logic [1:0]  cmd_src;
    logic [2:0]  readys;

    int compared   = 0;
    int mismatched = 0;

    assign readys = {ref_ready, zqc_ready, dir_ready};

    always #5 clk = ~clk;

    rpc_cmd_arbiter #(
        .CMD_WIDTH    (19),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .rpc_init_completed_i (init),
        .ref_valid_i          (ref_valid),
        .ref_ready_o          (ref_ready),
        .ref_cmd_i            (ref_cmd),
        .zqc_valid_i          (zqc_valid),
        .zqc_ready_o          (zqc_ready),
        .zqc_cmd_i            (zqc_cmd),
        .direct_cmd_valid_i   (dir_valid),
        .direct_cmd_ready_o   (dir_ready),
        .direct_cmd_i         (dir_cmd),
        .cmd_valid_o          (cmd_valid),
        .cmd_ready_i          (cmd_ready),
        .cmd_o                (cmd_out),
        .cmd_src_o            (cmd_src),
        .busy_o               (busy)
    );

    task automatic test_reset();
        rst_n = 1'b0; init = 1'b0; cmd_ready = 1'b0;
        ref_valid = 1'b0; zqc_valid = 1'b0; dir_valid = 1'b0;
        ref_cmd = REF_CMD; zqc_cmd = ZQC_CMD; dir_cmd = DIR_CMD;
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if ({cmd_valid, busy, cmd_src, cmd_out, readys} !== 25'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got v=%b busy=%b src=%0d cmd=%h rdy=%b, need all 0",
                     cmd_valid, busy, cmd_src, cmd_out, readys);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_init_gate();
        @(negedge clk); ref_valid = 1'b1; dir_valid = 1'b1; cmd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            compared++;
            if ({readys, cmd_valid} !== 4'b0000) begin
                mismatched++;
                $display("FAIL pre_init_cycle%0d: rdy=%b v=%b, need rdy=000 v=0", k, readys, cmd_valid);
            end
        end
        @(negedge clk); init = 1'b1; cmd_ready = 1'b0; #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++;
            $display("FAIL init_rise_grant: rdy=%b, need 100", readys);
        end
        @(negedge clk); ref_valid = 1'b0; dir_valid = 1'b0; #1;
        compared++;
        if ({cmd_valid, busy, cmd_src, cmd_out, readys} !== {1'b1, 1'b1, 2'd0, REF_CMD, 3'b000}) begin
            mismatched++;
            $display("FAIL init_first_cmd: v=%b busy=%b src=%0d cmd=%h rdy=%b, need 1 1 0 %h 000",
                     cmd_valid, busy, cmd_src, cmd_out, readys, REF_CMD);
        end
        cmd_ready = 1'b1;
        @(negedge clk); #1;
        compared++;
        if ({cmd_valid, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL init_handshake_idle: v=%b busy=%b, need 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk); ref_valid = 1'b1; zqc_valid = 1'b1; dir_valid = 1'b1; cmd_ready = 1'b1; #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++; $display("FAIL sim_grant_ref: rdy=%b, need 100", readys);
        end
        @(negedge clk); ref_valid = 1'b0; #1;
        compared++;
        if ({cmd_valid, cmd_src, cmd_out, readys} !== {1'b1, 2'd0, REF_CMD, 3'b000}) begin
            mismatched++;
            $display("FAIL sim_cmd_ref: v=%b src=%0d cmd=%h rdy=%b, need 1 0 %h 000",
                     cmd_valid, cmd_src, cmd_out, readys, REF_CMD);
        end
        @(negedge clk); #1;
        compared++;
        if ({cmd_valid, readys} !== 4'b0010) begin
            mismatched++; $display("FAIL sim_grant_zqc: v=%b rdy=%b, need 0 010", cmd_valid, readys);
        end
        @(negedge clk); zqc_valid = 1'b0; #1;
        compared++;
        if ({cmd_valid, cmd_src, cmd_out} !== {1'b1, 2'd1, ZQC_CMD}) begin
            mismatched++;
            $display("FAIL sim_cmd_zqc: v=%b src=%0d cmd=%h, need 1 1 %h", cmd_valid, cmd_src, cmd_out, ZQC_CMD);
        end
        @(negedge clk); #1;
        compared++;
        if ({cmd_valid, readys} !== 4'b0001) begin
            mismatched++; $display("FAIL sim_grant_dir: v=%b rdy=%b, need 0 001", cmd_valid, readys);
        end
        @(negedge clk); dir_valid = 1'b0; #1;
        compared++;
        if ({cmd_valid, cmd_src, cmd_out} !== {1'b1, 2'd2, DIR_CMD}) begin
            mismatched++;
            $display("FAIL sim_cmd_dir: v=%b src=%0d cmd=%h, need 1 2 %h", cmd_valid, cmd_src, cmd_out, DIR_CMD);
        end
        @(negedge clk); #1;
        compared++;
        if ({cmd_valid, readys} !== 4'b0000) begin
            mismatched++; $display("FAIL sim_drain: v=%b rdy=%b, need 0 000", cmd_valid, readys);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk); dir_valid = 1'b1; cmd_ready = 1'b0; #1;
        compared++;
        if (readys !== 3'b001) begin
            mismatched++; $display("FAIL bp_grant: rdy=%b, need 001", readys);
        end
        @(negedge clk); dir_valid = 1'b0; zqc_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            compared++;
            if ({cmd_out, busy, cmd_valid, readys} !== {DIR_CMD, 1'b1, 1'b1, 3'b000}) begin
                mismatched++;
                $display("FAIL bp_hold_cycle%0d: cmd=%h busy=%b v=%b rdy=%b, need %h 1 1 000",
                         k, cmd_out, busy, cmd_valid, readys, DIR_CMD);
            end
        end
        @(negedge clk); cmd_ready = 1'b1;
        @(negedge clk); #1;
        compared++;
        if ({cmd_valid, busy, readys} !== 5'b00010) begin
            mismatched++;
            $display("FAIL bp_release_idle: v=%b busy=%b rdy=%b, need 0 0 010", cmd_valid, busy, readys);
        end
        @(negedge clk); zqc_valid = 1'b0; #1;
        compared++;
        if ({cmd_valid, cmd_src, cmd_out} !== {1'b1, 2'd1, ZQC_CMD}) begin
            mismatched++;
            $display("FAIL bp_next_cmd: v=%b src=%0d cmd=%h, need 1 1 %h", cmd_valid, cmd_src, cmd_out, ZQC_CMD);
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        @(negedge clk); ref_valid = 1'b1; dir_valid = 1'b1; cmd_ready = 1'b1; #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++; $display("FAIL starve_first_ref: rdy=%b, need 100", readys);
        end
        @(negedge clk);
        @(negedge clk); #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++; $display("FAIL starve_second_ref: rdy=%b, need 100", readys);
        end
        @(negedge clk);
        @(negedge clk); #1;
        compared++;
        if (readys !== 3'b001) begin
            mismatched++; $display("FAIL starve_promote_dir: rdy=%b, need 001", readys);
        end
        @(negedge clk); dir_valid = 1'b0; #1;
        compared++;
        if ({cmd_valid, cmd_src} !== 3'b110) begin
            mismatched++; $display("FAIL starve_dir_src: v=%b src=%0d, need 1 2", cmd_valid, cmd_src);
        end
        @(negedge clk); #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++; $display("FAIL starve_ref_after: rdy=%b, need 100", readys);
        end
        @(negedge clk); ref_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_init_drop();
        @(negedge clk); ref_valid = 1'b1; zqc_valid = 1'b1; cmd_ready = 1'b0; #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++; $display("FAIL drop_grant: rdy=%b, need 100", readys);
        end
        @(negedge clk); init = 1'b0; cmd_ready = 1'b1; #1;
        compared++;
        if ({cmd_valid, cmd_src} !== 3'b100) begin
            mismatched++; $display("FAIL drop_hold: v=%b src=%0d, need 1 0", cmd_valid, cmd_src);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            compared++;
            if ({cmd_valid, readys} !== 4'b0000) begin
                mismatched++;
                $display("FAIL drop_no_grant%0d: v=%b rdy=%b, need 0 000", k, cmd_valid, readys);
            end
        end
        @(negedge clk); init = 1'b1; #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++; $display("FAIL drop_regrant: rdy=%b, need 100", readys);
        end
        @(negedge clk); ref_valid = 1'b0; zqc_valid = 1'b0;
        @(negedge clk); #1;
        compared++;
        if ({cmd_valid, readys} !== 4'b0000) begin
            mismatched++; $display("FAIL drop_withdrawn: v=%b rdy=%b, need 0 000", cmd_valid, readys);
        end
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk); dir_valid = 1'b1; cmd_ready = 1'b0; #1;
        compared++;
        if (readys !== 3'b001) begin
            mismatched++; $display("FAIL rst_grant: rdy=%b, need 001", readys);
        end
        repeat (5) @(negedge clk);
        #1;
        compared++;
        if ({cmd_valid, cmd_src, cmd_out} !== {1'b1, 2'd2, DIR_CMD}) begin
            mismatched++;
            $display("FAIL rst_hold: v=%b src=%0d cmd=%h, need 1 2 %h", cmd_valid, cmd_src, cmd_out, DIR_CMD);
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ({cmd_valid, busy, cmd_src, cmd_out, readys} !== 25'd0) begin
            mismatched++;
            $display("FAIL rst_async_clear: v=%b busy=%b src=%0d cmd=%h rdy=%b, need all 0",
                     cmd_valid, busy, cmd_src, cmd_out, readys);
        end
        @(negedge clk); rst_n = 1'b1; ref_valid = 1'b1; #1;
        compared++;
        if (readys !== 3'b100) begin
            mismatched++; $display("FAIL rst_counter_cleared: rdy=%b, need 100", readys);
        end
        @(negedge clk); ref_valid = 1'b0; dir_valid = 1'b0; cmd_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_simultaneous();
        test_backpressure();
        test_starvation();
        test_init_drop();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
